// File: rtl/mem_controller.sv
// Open-row backing-memory controller: one read or write in flight, row misses repaired via arbiter handshake.
// Optional hit/miss statistics ports are built when MEMCTRL_STATS_EN is defined.
module mem_controller #(
  parameter int DEPTH     = 1024,
  parameter int ROW_WORDS = 16,
  parameter int RD_LAT    = 3,
  parameter int WR_LAT    = 2,
  parameter int ACT_LAT   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        raddr_valid,
  input  logic [31:0] raddr,
  input  logic        waddr_valid,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  input  logic [15:0] wmask,
  input  logic        repair_resolved,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        read_miss_repair,
  output logic        write_miss_repair,
  output logic [31:0] missed_addr,
  output logic        busy
`ifdef MEMCTRL_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int ROW_SH = $clog2(ROW_WORDS);
  localparam int CNT_W  = 8;
  // ACCESS counters are preloaded with LAT-2 so ACCESS lasts LAT-1 cycles.
  localparam logic [CNT_W-1:0] RD_CNT  = CNT_W'(RD_LAT - 2);
  localparam logic [CNT_W-1:0] WR_CNT  = CNT_W'(WR_LAT - 2);
  localparam logic [CNT_W-1:0] ACT_CNT = CNT_W'(ACT_LAT - 1);

  typedef enum logic [2:0] {IDLE, MISS, ACT, ACCESS, RESP} state_e;

  state_e           state_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wmask_q;
  logic             is_wr_q;
  logic [IDX_W-1:0] open_row_q;
  logic             row_valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      mem [DEPTH];

  logic [31:0]      req_addr;
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] idx_q;
  logic             req_valid;
  logic             req_hit;
  logic             wr_commit;
  logic             unused_wmask;

  assign req_addr     = waddr_valid ? waddr : raddr;
  assign req_idx      = req_addr[IDX_W+1:2];
  assign idx_q        = addr_q[IDX_W+1:2];
  assign req_valid    = waddr_valid | raddr_valid;
  assign req_hit      = row_valid_q && ((req_idx >> ROW_SH) == open_row_q);
  assign wr_commit    = (state_q == ACCESS) && is_wr_q && (cnt_q == '0);
  assign unused_wmask = ^wmask[15:4];

  // Array is not reset; a reset aborts the FSM before wr_commit can fire.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      addr_q            <= '0;
      wdata_q           <= '0;
      wmask_q           <= '0;
      is_wr_q           <= 1'b0;
      open_row_q        <= '0;
      row_valid_q       <= 1'b0;
      cnt_q             <= '0;
      rdata             <= '0;
      rdata_valid       <= 1'b0;
      read_miss_repair  <= 1'b0;
      write_miss_repair <= 1'b0;
      missed_addr       <= '0;
      busy              <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= wdata;
            wmask_q <= wmask[3:0];
            is_wr_q <= waddr_valid;
            busy    <= 1'b1;
            if (req_hit) begin
              state_q <= ACCESS;
              cnt_q   <= waddr_valid ? WR_CNT : RD_CNT;
            end else begin
              state_q           <= MISS;
              read_miss_repair  <= ~waddr_valid;
              write_miss_repair <= waddr_valid;
              missed_addr       <= req_addr;
            end
          end
        end
        MISS: begin
          if (repair_resolved) begin
            read_miss_repair  <= 1'b0;
            write_miss_repair <= 1'b0;
            state_q           <= ACT;
            cnt_q             <= ACT_CNT;
          end
        end
        ACT: begin
          if (cnt_q == '0) begin
            open_row_q  <= idx_q >> ROW_SH;
            row_valid_q <= 1'b1;
            state_q     <= ACCESS;
            cnt_q       <= is_wr_q ? WR_CNT : RD_CNT;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            if (is_wr_q) begin
              state_q <= IDLE;
              busy    <= 1'b0;
            end else begin
              state_q     <= RESP;
              rdata       <= mem[idx_q];
              rdata_valid <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          rdata_valid <= 1'b0;
          busy        <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MEMCTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state_q == IDLE && req_valid) begin
      if (req_hit) begin
        if (hit_count != '1) hit_count <= hit_count + 1'b1;
      end else begin
        if (miss_count != '1) miss_count <= miss_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller: vector table of row hits/misses plus hand-written
// sequences for miss hold, simultaneous requests and reset during a write.
module tb_mem_controller;

  localparam int RD_LAT  = 3;
  localparam int WR_LAT  = 2;
  localparam int ACT_LAT = 4;
  localparam int MISS_WAIT = 3;

  logic        clk;
  logic        rst_n;
  logic        raddr_valid;
  logic [31:0] raddr;
  logic        waddr_valid;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic [15:0] wmask;
  logic        repair_resolved;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        read_miss_repair;
  logic        write_miss_repair;
  logic [31:0] missed_addr;
  logic        busy;
`ifdef MEMCTRL_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mem_controller dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .raddr_valid       (raddr_valid),
    .raddr             (raddr),
    .waddr_valid       (waddr_valid),
    .waddr             (waddr),
    .wdata             (wdata),
    .wmask             (wmask),
    .repair_resolved   (repair_resolved),
    .rdata             (rdata),
    .rdata_valid       (rdata_valid),
    .read_miss_repair  (read_miss_repair),
    .write_miss_repair (write_miss_repair),
    .missed_addr       (missed_addr),
    .busy              (busy)
`ifdef MEMCTRL_STATS_EN
    ,
    .hit_count         (hit_count),
    .miss_count        (miss_count)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " rdata"}, rdata, 32'h0);
    check({tag, " rdata_valid"}, {31'h0, rdata_valid}, 32'h0);
    check({tag, " read_miss"}, {31'h0, read_miss_repair}, 32'h0);
    check({tag, " write_miss"}, {31'h0, write_miss_repair}, 32'h0);
    check({tag, " missed_addr"}, missed_addr, 32'h0);
    check({tag, " busy"}, {31'h0, busy}, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: issues one request, resolves a miss after MISS_WAIT cycles, checks latency/data.
  task automatic do_access(input string name, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [15:0] m,
                           input bit exp_miss, input logic [31:0] exp_rd);
    int  n;
    int  exp_lat;
    bit  done;
    logic got_miss;
    if (wr) begin
      waddr_valid = 1'b1; waddr = a; wdata = d; wmask = m;
    end else begin
      raddr_valid = 1'b1; raddr = a;
    end
    step();
    waddr_valid = 1'b0;
    raddr_valid = 1'b0;
    got_miss = read_miss_repair | write_miss_repair;
    check({name, " miss"}, {31'h0, got_miss}, {31'h0, exp_miss});
    check({name, " busy"}, {31'h0, busy}, 32'h1);
    n = 0;
    if (got_miss) begin
      check({name, " missed_addr"}, missed_addr, a);
      check({name, " miss kind"}, {30'h0, write_miss_repair, read_miss_repair},
            wr ? 32'h2 : 32'h1);
      repeat (MISS_WAIT - 1) begin step(); n++; end
      repair_resolved = 1'b1;
      step(); n++;
      repair_resolved = 1'b0;
    end
    done = 1'b0;
    while (!done && n < 60) begin
      done = wr ? !busy : rdata_valid;
      if (!done) begin step(); n++; end
    end
    exp_lat = (exp_miss ? MISS_WAIT + ACT_LAT : 0) + (wr ? WR_LAT : RD_LAT) - 1;
    check({name, " latency"}, 32'(n), 32'(exp_lat));
    if (!wr && done) begin
      check({name, " rdata"}, rdata, exp_rd);
      step();
      check({name, " pulse end"}, {31'h0, rdata_valid}, 32'h0);
      check({name, " rdata hold"}, rdata, exp_rd);
      check({name, " idle"}, {31'h0, busy}, 32'h0);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [15:0] mask;
    bit          miss;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int n;
    // Row 1 (word indexes 16..31) is open after the first hand sequence.
    vecs[0]  = '{1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 16'h000F, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0044, 32'h0,         16'h0000, 1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_0044, 32'h1122_3344, 16'h0005, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_0044, 32'h0,         16'h0000, 1'b0, 32'hDE22_BE44};
    vecs[4]  = '{1'b1, 32'h0000_0048, 32'hCAFE_F00D, 16'hFFFF, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_0048, 32'h0,         16'h0000, 1'b0, 32'hCAFE_F00D};
    vecs[6]  = '{1'b1, 32'h0000_0048, 32'h1234_5678, 16'h0000, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_0048, 32'h0,         16'h0000, 1'b0, 32'hCAFE_F00D};
    vecs[8]  = '{1'b1, 32'h0000_0080, 32'hA5A5_A5A5, 16'h000F, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, 32'h0000_0080, 32'h0,         16'h0000, 1'b0, 32'hA5A5_A5A5};
    vecs[10] = '{1'b0, 32'h0000_0044, 32'h0,         16'h0000, 1'b1, 32'hDE22_BE44};
    vecs[11] = '{1'b1, 32'h0000_1044, 32'h5566_7788, 16'h000F, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 32'h0000_0047, 32'h0,         16'h0000, 1'b0, 32'h5566_7788};

    rst_n = 1'b0;
    raddr_valid = 1'b0; raddr = '0;
    waddr_valid = 1'b0; waddr = '0;
    wdata = '0; wmask = '0; repair_resolved = 1'b0;
    #2;
    check_idle_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // repair_resolved in IDLE has no effect
    repair_resolved = 1'b1;
    step();
    repair_resolved = 1'b0;
    check("resolve in idle busy", {31'h0, busy}, 32'h0);

    // Read miss held for 5 cycles, then resolved
    raddr = 32'h40; raddr_valid = 1'b1;
    step();
    raddr_valid = 1'b0;
    check("s1 read_miss", {31'h0, read_miss_repair}, 32'h1);
    check("s1 write_miss", {31'h0, write_miss_repair}, 32'h0);
    check("s1 missed_addr", missed_addr, 32'h40);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("s1 hold %0d", i), {31'h0, read_miss_repair}, 32'h1);
    end
    repair_resolved = 1'b1;
    step();
    repair_resolved = 1'b0;
    check("s1 flag drop", {31'h0, read_miss_repair}, 32'h0);
    n = 0;
    while (!rdata_valid && n < 50) begin step(); n++; end
    check("s1 act+read latency", 32'(n), 32'(ACT_LAT + RD_LAT - 1));
    step();
    check("s1 single pulse", {31'h0, rdata_valid}, 32'h0);

    // Vector table
    for (int i = 0; i < 13; i++) begin
      do_access($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data,
                vecs[i].mask, vecs[i].miss, vecs[i].exp);
`ifdef MEMCTRL_STATS_EN
      if (i == 1) begin
        check("stats miss", miss_count, 32'd1);
        check("stats hit", hit_count, 32'd2);
      end
`endif
    end

    // Simultaneous read and write: write first, read ignored while busy
    raddr = 32'h48; raddr_valid = 1'b1;
    waddr = 32'h4C; wdata = 32'h0BAD_F00D; wmask = 16'h000F; waddr_valid = 1'b1;
    step();
    waddr_valid = 1'b0;
    check("s4 busy", {31'h0, busy}, 32'h1);
    check("s4 no miss", {30'h0, write_miss_repair, read_miss_repair}, 32'h0);
    step();
    raddr_valid = 1'b0;
    check("s4 write done", {31'h0, busy}, 32'h0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rdata_valid || busy) n++;
    end
    check("s4 read ignored", 32'(n), 32'h0);
    do_access("s4 readback", 1'b0, 32'h4C, 32'h0, 16'h0, 1'b0, 32'h0BAD_F00D);

    // Reset during ACCESS of a write
    waddr = 32'h4C; wdata = 32'hFFFF_FFFF; wmask = 16'h000F; waddr_valid = 1'b1;
    step();
    waddr_valid = 1'b0;
    check("s6 in access", {31'h0, busy}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check_idle_outputs("s6 async reset");
    #1 rst_n = 1'b1;
    step();
    check("s6 still idle", {31'h0, busy}, 32'h0);
    do_access("s6 old data", 1'b0, 32'h4C, 32'h0, 16'h0, 1'b1, 32'h0BAD_F00D);
`ifdef MEMCTRL_STATS_EN
    check("s6 stats miss", miss_count, 32'd1);
    check("s6 stats hit", hit_count, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
